reader_serializer: RTL and testbench

Upstream stage of the byte-level readback checker. It pops 32-bit words from the Reader FIFO and emits them as a contiguous little-endian byte stream: byte 0 (bits [7:0]) first, one byte per cycle. Each byte carries a 2-bit lane index. The FIFO read-enable pulse is exported so the downstream checker can advance its DMA read address in lock-step. Valid is held high, without gaps, for exactly `buffer_length` bytes per transfer.

---
 rtl/reader_serializer.sv | 197 +++++++++++++++++++
 tb/tb_reader_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reader_serializer.sv
// -----------------------------------------------------------------------------
// reader_serializer
//
// Pops 32-bit words from the Reader FIFO and streams them out little-endian,
// one byte per cycle, with valid held high without gaps for the requested
// byte count. The FIFO pop pulse is exported so the downstream checker can
// step its DMA read address in lock-step with this block.
//
// Ports:
//   CLK                     in   clock, rising edge
//   RESETn                  in   synchronous active-low reset
//   start                   in   one-cycle transfer request, honoured in IDLE only
//   buffer_length   [5:0]   in   transfer length in bytes, latched on start
//   fifo_count      [4:0]   in   Reader FIFO occupancy in words
//   fifo_empty              in   Reader FIFO empty flag
//   fifo_rd_data    [31:0]  in   FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en              out  FIFO pop pulse (also the checker's read enable)
//   serialized_output [7:0] out  current byte
//   serialized_output_valid out  byte valid
//   serialize_counter [1:0] out  byte lane of the current byte (0 = bits [7:0])
//   busy                    out  high in every state except IDLE
//   done                    out  one-cycle end-of-transfer pulse
//   underrun                out  sticky: FIFO ran dry at a prefetch slot
// -----------------------------------------------------------------------------
module reader_serializer (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    input  logic [5:0]  buffer_length,
    input  logic [4:0]  fifo_count,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic [7:0]  serialized_output,
    output logic        serialized_output_valid,
    output logic [1:0]  serialize_counter,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  len_q, len_d;
    logic [4:0]  words_q, words_d;
    logic [31:0] word_q, word_d;
    logic [5:0]  bytes_left_q, bytes_left_d;
    logic [1:0]  lane_q, lane_d;
    logic        underrun_q, underrun_d;
    logic        pop_q;

    // ARM releases only once the whole transfer is already in the FIFO, so
    // the prefetch pops during SHIFT can only fail if the FIFO is drained
    // by someone else.
    logic arm_ready;
    assign arm_ready = (state_q == S_ARM) && (fifo_count >= words_q);

    // Fetch the next word while lane 2 is on the bus; its data arrives during
    // lane 3 and is loaded at the 3 -> 0 wrap.
    logic prefetch_slot;
    assign prefetch_slot = (state_q == S_SHIFT) && (lane_q == 2'd2) &&
                           (bytes_left_q > 6'd2);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    // NOTE: the word register is reset together with the rest; it is a single
    // word, and a clean value keeps the output bus quiet after reset.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            words_q      <= '0;
            word_q       <= '0;
            bytes_left_q <= '0;
            lane_q       <= '0;
            underrun_q   <= 1'b0;
            pop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            words_q      <= words_d;
            word_q       <= word_d;
            bytes_left_q <= bytes_left_d;
            lane_q       <= lane_d;
            underrun_q   <= underrun_d;
            pop_q        <= fifo_rd_en;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a hold default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        words_d      = words_q;
        word_d       = word_q;
        bytes_left_d = bytes_left_q;
        lane_d       = lane_q;
        underrun_d   = underrun_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = buffer_length;
                    // ceil(len/4) needs the carry out of len+3 (63 -> 16 words)
                    words_d    = 5'(({1'b0, buffer_length} + 7'd3) >> 2);
                    underrun_d = 1'b0;
                    state_d    = (buffer_length == 6'd0) ? S_DONE : S_ARM;
                end
            end

            S_ARM: begin
                if (arm_ready) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                word_d       = fifo_rd_data;
                bytes_left_d = len_q;
                lane_d       = 2'd0;
                state_d      = S_SHIFT;
            end

            S_SHIFT: begin
                bytes_left_d = bytes_left_q - 6'd1;
                lane_d       = lane_q + 2'd1;
                // A pop last cycle means fresh data is on the bus now.
                if (pop_q) begin
                    word_d = fifo_rd_data;
                end
                if (prefetch_slot && fifo_empty) begin
                    underrun_d = 1'b1;
                end
                // Underrun truncates the stream after the current word.
                if ((bytes_left_q == 6'd1) || ((lane_q == 2'd3) && underrun_q)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_rd_en              = 1'b0;
        serialized_output       = 8'd0;
        serialized_output_valid = 1'b0;
        serialize_counter       = 2'd0;
        busy                    = (state_q != S_IDLE);
        done                    = 1'b0;
        underrun                = underrun_q;

        case (state_q)
            S_ARM: begin
                fifo_rd_en = arm_ready;
            end

            S_SHIFT: begin
                fifo_rd_en              = prefetch_slot && !fifo_empty;
                serialized_output       = word_q[{lane_q, 3'b000} +: 8];
                serialized_output_valid = 1'b1;
                serialize_counter       = lane_q;
            end

            S_DONE: begin
                done = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reader_serializer.sv
// -----------------------------------------------------------------------------
// tb_reader_serializer
//
// Drives reader_serializer with directed and randomized transfers. A small
// FIFO model supplies data; expected per-cycle outputs are computed from the
// transfer-level timing rules (pop cycles, byte schedule, done cycle) and
// compared against the design once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_reader_serializer;

    localparam int TMAX = 200;

    logic        CLK;
    logic        RESETn;
    logic        start;
    logic [5:0]  buffer_length;
    logic [4:0]  fifo_count;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic [7:0]  serialized_output;
    logic        serialized_output_valid;
    logic [1:0]  serialize_counter;
    logic        busy;
    logic        done;
    logic        underrun;

    reader_serializer dut (
        .CLK                     (CLK),
        .RESETn                  (RESETn),
        .start                   (start),
        .buffer_length           (buffer_length),
        .fifo_count              (fifo_count),
        .fifo_empty              (fifo_empty),
        .fifo_rd_data            (fifo_rd_data),
        .fifo_rd_en              (fifo_rd_en),
        .serialized_output       (serialized_output),
        .serialized_output_valid (serialized_output_valid),
        .serialize_counter       (serialize_counter),
        .busy                    (busy),
        .done                    (done),
        .underrun                (underrun)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    bit          ur_prev = 1'b0;

    logic [31:0] exp_valid [TMAX];
    logic [31:0] exp_byte  [TMAX];
    logic [31:0] exp_ctr   [TMAX];
    logic [31:0] exp_pop   [TMAX];
    logic [31:0] exp_done  [TMAX];
    logic [31:0] exp_busy  [TMAX];
    logic [31:0] exp_ur    [TMAX];

    task automatic check(input string tag, input int t,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // One transfer. len: byte count; w: ARM cycles with too little occupancy;
    // ur_k: byte index of the prefetch slot where the FIFO reads empty (-1 none);
    // stray_at: byte index at which a stray start is pulsed (-1 none);
    // rst_at: byte index during which reset is asserted (-1 none);
    // directed: use the 0x44332211 / 0x88776655 words first.
    task automatic run(input int len, input int w, input int ur_k,
                       input int stray_at, input int rst_at, input bit directed);
        int          words;
        int          n_emit;
        int          t_done;
        int          last;
        int          tr;
        int          pops_exp;
        int          pops_obs;
        bit          popped;
        logic [31:0] src[$];

        words = (len + 3) / 4;
        fifo_q.delete();
        for (int i = 0; i < words; i++) begin
            if (directed && i == 0)      src.push_back(32'h44332211);
            else if (directed && i == 1) src.push_back(32'h88776655);
            else                         src.push_back($urandom);
            fifo_q.push_back(src[i]);
        end

        for (int t = 0; t < TMAX; t++) begin
            exp_valid[t] = 0; exp_byte[t] = 0; exp_ctr[t] = 0; exp_pop[t] = 0;
            exp_done[t]  = 0; exp_busy[t] = 0; exp_ur[t]  = 0;
        end
        exp_ur[0] = 32'(ur_prev);

        if (len == 0) begin
            t_done = 1;
        end else begin
            exp_pop[1 + w] = 1;
            n_emit = len;
            for (int k = 2; len - k > 2; k += 4) begin
                if (k == ur_k) begin
                    n_emit = k + 2;
                    for (int t = 3 + w + k + 1; t < TMAX; t++) exp_ur[t] = 1;
                    break;
                end
                exp_pop[3 + w + k] = 1;
            end
            for (int b = 0; b < n_emit; b++) begin
                exp_valid[3 + w + b] = 1;
                exp_byte[3 + w + b]  = (src[b / 4] >> (8 * (b % 4))) & 32'hFF;
                exp_ctr[3 + w + b]   = 32'(b % 4);
            end
            t_done = 3 + w + n_emit;
        end
        exp_done[t_done] = 1;
        for (int t = 1; t <= t_done; t++) exp_busy[t] = 1;
        last = t_done + 3;

        tr = -1;
        if (rst_at >= 0) begin
            tr = 3 + w + rst_at;
            for (int t = tr + 1; t < TMAX; t++) begin
                exp_valid[t] = 0; exp_byte[t] = 0; exp_ctr[t] = 0; exp_pop[t] = 0;
                exp_done[t]  = 0; exp_busy[t] = 0; exp_ur[t]  = 0;
            end
            last = tr + 3;
        end

        pops_exp = 0;
        for (int t = 0; t <= last; t++) pops_exp += int'(exp_pop[t]);
        pops_obs = 0;
        popped   = 1'b0;

        for (int t = 0; t <= last; t++) begin
            // FIFO model: a pop last cycle presents its word this cycle.
            if (popped && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            else                             fifo_rd_data = $urandom;
            start         = (t == 0) || (stray_at >= 0 && t == 3 + w + stray_at);
            buffer_length = (t == 0) ? 6'(len) : 6'($urandom);
            RESETn        = !(t == tr);
            fifo_count    = (t >= 1 && t <= w) ? 5'(words - 1) : 5'(fifo_q.size());
            fifo_empty    = (ur_k >= 0 && t == 3 + w + ur_k) ? 1'b1 : (fifo_q.size() == 0);

            @(negedge CLK);
            check("valid",    t, 32'(serialized_output_valid), exp_valid[t]);
            check("byte",     t, 32'(serialized_output),       exp_byte[t]);
            check("lane",     t, 32'(serialize_counter),       exp_ctr[t]);
            check("rd_en",    t, 32'(fifo_rd_en),              exp_pop[t]);
            check("done",     t, 32'(done),                    exp_done[t]);
            check("busy",     t, 32'(busy),                    exp_busy[t]);
            check("underrun", t, 32'(underrun),                exp_ur[t]);
            popped = fifo_rd_en;
            if (fifo_rd_en) pops_obs++;

            @(posedge CLK);
            #1;
        end
        check("pop_count", last, 32'(pops_obs), 32'(pops_exp));

        start   = 1'b0;
        RESETn  = 1'b1;
        ur_prev = exp_ur[last][0];
        fifo_q.delete();
    endtask

    initial begin
        RESETn        = 1'b0;
        start         = 1'b0;
        buffer_length = '0;
        fifo_count    = '0;
        fifo_empty    = 1'b1;
        fifo_rd_data  = '0;

        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_valid",    0, 32'(serialized_output_valid), 32'd0);
        check("rst_byte",     0, 32'(serialized_output),       32'd0);
        check("rst_lane",     0, 32'(serialize_counter),       32'd0);
        check("rst_rd_en",    0, 32'(fifo_rd_en),              32'd0);
        check("rst_done",     0, 32'(done),                    32'd0);
        check("rst_busy",     0, 32'(busy),                    32'd0);
        check("rst_underrun", 0, 32'(underrun),                32'd0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        @(posedge CLK);
        #1;

        // Directed scenarios
        run(8, 0, -1, -1, -1, 1'b1);   // two full words
        run(6, 0, -1, -1, -1, 1'b1);   // partial final word
        run(0, 0, -1, -1, -1, 1'b1);   // empty transfer
        run(8, 5, -1, -1, -1, 1'b1);   // ARM waits five cycles
        run(8, 0,  2, -1, -1, 1'b1);   // underrun at first prefetch
        run(8, 0, -1,  4, -1, 1'b1);   // clears underrun; stray start ignored
        run(8, 0, -1, -1,  3, 1'b1);   // reset at byte index 3
        run(5, 0, -1, -1, -1, 1'b1);   // recovers after reset

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            int len;
            int w;
            int ur_k;
            int stray;
            int slots;
            len   = $urandom_range(0, 63);
            w     = (len == 0) ? 0 : $urandom_range(0, 3);
            ur_k  = -1;
            stray = -1;
            slots = 0;
            for (int k = 2; len - k > 2; k += 4) slots++;
            if (slots > 0 && $urandom_range(0, 3) == 0) begin
                ur_k = 2 + 4 * $urandom_range(0, slots - 1);
            end else if (len > 0 && $urandom_range(0, 2) == 0) begin
                stray = $urandom_range(0, len - 1);
            end
            run(len, w, ur_k, stray, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
